// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and helpers for the tristate bus arbiter.
// The FSM state type is exported so checkers and benches can observe it directly.
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  // Index of the highest set bit; callers pass a one-hot (or zero) vector.
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/ownership bundle between the bus drivers and the arbiter.
// req is a level request held for as long as a driver wants the bus; done is a
// one-cycle release pulse honoured only for the current owner; grant/oe are
// registered one-hot ownership and are never high for two drivers at once.
interface tristate_bus_arbiter_if
  import tristate_bus_pkg::*;
#(
  parameter int N_REQ = 4
) ();
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] oe;
  logic [IW-1:0]    owner_id;
  logic             bus_busy;
  logic             timeout;
  state_t           state;

  modport master (
    input  req, done,
    output grant, oe, owner_id, bus_busy, timeout, state
  );

  modport slave (
    output req, done,
    input  grant, oe, owner_id, bus_busy, timeout, state
  );
endinterface

// File: rtl/tristate_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request strictly after rr_ptr,
// wrapping around, so the last winner has the lowest priority.
module rr_priority_picker
  import tristate_bus_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic             valid,
  output logic [IW-1:0]    win_idx,
  output logic [N_REQ-1:0] win_onehot
);

  logic [IW-1:0] cand;

  always_comb begin
    valid      = 1'b0;
    win_onehot = '0;
    cand       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(rr_ptr) + i) % N_REQ);
      if (!valid && req[cand]) begin
        valid            = 1'b1;
        win_onehot[cand] = 1'b1;
      end
    end
  end

  assign win_idx = IW'(onehot_to_idx(32'(win_onehot)));

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus: one enable at a time, a dead
// turnaround gap between owners, and a hold timeout that forces release.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_MAX    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  tristate_bus_arbiter_if.master bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam int TW = (TURN_CYCLES < 1) ? 1 : $clog2(TURN_CYCLES + 1);
  // With no timeout the counter just parks at all-ones instead of wrapping.
  localparam logic [HW-1:0] HOLD_SAT  = (HOLD_MAX == 0) ? {HW{1'b1}} : HW'(HOLD_MAX);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES);

  state_t           state;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] oe;
  logic [IW-1:0]    owner_id;
  logic [IW-1:0]    rr_ptr;
  logic [HW-1:0]    hold_cnt;
  logic [TW-1:0]    turn_cnt;
  logic             timeout;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             owner_release;
  logic             hold_expired;
  logic             turn_done;
  logic             start_own;

  rr_priority_picker #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_picker (
    .req       (bus.req),
    .rr_ptr    (rr_ptr),
    .valid     (pick_valid),
    .win_idx   (pick_idx),
    .win_onehot(pick_onehot)
  );

  assign owner_release = !bus.req[owner_id] || bus.done[owner_id];
  assign hold_expired  = (HOLD_MAX != 0) && (hold_cnt == HW'(HOLD_MAX));
  assign turn_done     = (turn_cnt == TURN_LAST);
  // A waiting requester skips IDLE and takes the bus straight out of TURN.
  assign start_own     = pick_valid && ((state == IDLE) || ((state == TURN) && turn_done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      oe       <= '0;
      owner_id <= '0;
      rr_ptr   <= IW'(N_REQ - 1);
      hold_cnt <= '0;
      turn_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (start_own) begin
        state    <= OWN;
        grant    <= pick_onehot;
        oe       <= pick_onehot;
        owner_id <= pick_idx;
        rr_ptr   <= pick_idx;
        hold_cnt <= HW'(1);
      end else begin
        case (state)
          IDLE: ;
          OWN: begin
            if (owner_release || hold_expired) begin
              state    <= TURN;
              grant    <= '0;
              oe       <= '0;
              turn_cnt <= TW'(1);
              // A voluntary release wins over a simultaneous expiry.
              timeout  <= hold_expired && !owner_release;
            end else if (hold_cnt != HOLD_SAT) begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          TURN: begin
            if (turn_done) state <= IDLE;
            else           turn_cnt <= turn_cnt + TW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.grant    = grant;
  assign bus.oe       = oe;
  assign bus.owner_id = owner_id;
  assign bus.bus_busy = (state != IDLE);
  assign bus.timeout  = timeout;
  assign bus.state    = state;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-level ownership model through a scoreboard.
module tb_tristate_bus_arbiter;
  import tristate_bus_pkg::*;

  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int TURN = 1;
  localparam int IW   = 2;
  localparam int EW   = N + 2 + IW;

  logic clk;
  logic rst;

  tristate_bus_arbiter_if #(.N_REQ(N)) bus ();

  tristate_bus_arbiter #(
    .N_REQ      (N),
    .HOLD_MAX   (HOLD),
    .TURN_CYCLES(TURN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected {oe, bus_busy, timeout, owner_id} per cycle, tagged with the cycle it applies to.
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  // Reference model: phase 0 = free, 1 = owned, 2 = turnaround gap.
  int m_phase, m_owner, m_last, m_owned, m_gap;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int pick(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_owner = 0;
    m_last  = N - 1;
    m_owned = 0;
    m_gap   = 0;
  endtask

  task automatic model_take(input int w);
    m_phase = 1;
    m_owner = w;
    m_last  = w;
    m_owned = 1;
  endtask

  // Predicts the outcome of the coming clock edge from the inputs just driven.
  task automatic model_eval();
    int w;
    logic rel, expd, to;
    logic [N-1:0] eoe;
    to = 1'b0;
    case (m_phase)
      0: begin
        w = pick(m_last, bus.req);
        if (w >= 0) model_take(w);
      end
      1: begin
        rel  = !bus.req[m_owner] || bus.done[m_owner];
        expd = (HOLD != 0) && (m_owned == HOLD);
        if (rel || expd) begin
          m_phase = 2;
          m_gap   = 1;
          to      = expd && !rel;
        end else if (HOLD == 0 || m_owned < HOLD) begin
          m_owned++;
        end
      end
      default: begin
        if (m_gap >= TURN) begin
          w = pick(m_last, bus.req);
          if (w >= 0) model_take(w);
          else        m_phase = 0;
        end else begin
          m_gap++;
        end
      end
    endcase
    eoe = (m_phase == 1) ? N'(1 << m_owner) : '0;
    exp_q.push_back({eoe, (m_phase != 0), to, IW'(m_owner)});
    exp_cyc_q.push_back(cyc + 1);
  endtask

  // Drive inputs for one edge, record the expectation, then let the edge happen.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
    bus.req  = r;
    bus.done = d;
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset_mid_run();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_oe", 32'(bus.oe), 32'(0));
    check("async_rst_grant", 32'(bus.grant), 32'(0));
    check("async_rst_busy", 32'(bus.bus_busy), 32'(0));
    exp_q.delete();
    exp_cyc_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: invariants every cycle, scoreboard compare when an expectation is due.
  initial begin
    logic [N-1:0]  prev_oe;
    int            zero_run;
    logic [EW-1:0] e;
    prev_oe  = '0;
    zero_run = TURN;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_oe  = '0;
        zero_run = TURN;
        continue;
      end
      check("onehot0_oe", 32'($onehot0(bus.oe)), 32'(1));
      if (bus.oe != '0 && prev_oe == '0) check("turn_gap_ok", 32'(zero_run >= TURN), 32'(1));
      if (bus.oe == '0) zero_run++;
      else              zero_run = 0;
      prev_oe = bus.oe;
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        void'(exp_cyc_q.pop_front());
        e = exp_q.pop_front();
        check("oe", 32'(bus.oe), 32'(e[EW-1 -: N]));
        check("grant", 32'(bus.grant), 32'(e[EW-1 -: N]));
        check("bus_busy", 32'(bus.bus_busy), 32'(e[IW+1]));
        check("timeout", 32'(bus.timeout), 32'(e[IW]));
        check("owner_id", 32'(bus.owner_id), 32'(e[IW-1:0]));
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] d;
    model_reset();
    rst      = 1'b1;
    bus.req  = 4'b1111;
    bus.done = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset holds everything off even with all drivers requesting.
    check("rst_grant", 32'(bus.grant), 32'(0));
    check("rst_oe", 32'(bus.oe), 32'(0));
    check("rst_busy", 32'(bus.bus_busy), 32'(0));
    rst = 1'b0;
    step(4'b1111, '0);
    check("first_grant", 32'(bus.grant), 32'(4'b0001));
    check("first_owner", 32'(bus.owner_id), 32'(0));

    // Round robin between drivers 1 and 3 with done releases.
    for (int i = 0; i < 4; i++) begin
      step(4'b1010, '0);
      step(4'b1010, '0);
      step(4'b1010, 4'b1111);
    end
    repeat (3) step('0, '0);

    // Lone holder with no done: timeout then re-grant.
    repeat (24) step(4'b0100, '0);
    repeat (3) step('0, '0);

    // Stuck owner 0 with driver 2 waiting.
    repeat (24) step(4'b0101, '0);
    repeat (3) step('0, '0);

    // Owner drops req exactly at hold expiry: normal release, no timeout.
    repeat (HOLD) step(4'b0100, '0);
    step('0, '0);
    repeat (3) step('0, '0);
    check("release_at_expiry_idle", 32'(bus.bus_busy), 32'(0));

    // Random traffic.
    r = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
      d = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
      step(r, d);
    end
    repeat (3) step('0, '0);

    // Reset while driver 1 owns the bus.
    for (int i = 0; i < 10 && bus.oe != 4'b0010; i++) step(4'b0010, '0);
    check("pre_reset_owner", 32'(bus.oe), 32'(4'b0010));
    async_reset_mid_run();
    step(4'b1111, '0);
    check("post_reset_grant", 32'(bus.grant), 32'(4'b0001));
    repeat (4) step('0, '0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
